// File: rtl/pipelined_block_cla_if.sv
// Operand/result handshake bundle for pipelined_block_cla.
// The ov_o signal exists only when CLA_OVERFLOW_EN is defined.
interface pipelined_block_cla_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             c_i;
   logic             sub_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] o_o;
   logic             c_o;
`ifdef CLA_OVERFLOW_EN
   logic             ov_o;
`endif

   modport slave (
      input  valid_i, a_i, b_i, c_i, sub_i, ready_i,
      output ready_o, valid_o, o_o, c_o
`ifdef CLA_OVERFLOW_EN
      , output ov_o
`endif
   );

   modport master (
      output valid_i, a_i, b_i, c_i, sub_i, ready_i,
      input  ready_o, valid_o, o_o, c_o
`ifdef CLA_OVERFLOW_EN
      , input ov_o
`endif
   );
endinterface

// File: rtl/pipelined_block_cla.sv
// Two-stage pipelined block carry-lookahead adder/subtractor with valid/ready flow control.
// Optional signed-overflow output ov_o is built only when CLA_OVERFLOW_EN is defined.
module pipelined_block_cla #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   pipelined_block_cla_if.slave bus
);
   localparam int NG = WIDTH / GROUP;

   // The top G bit of each group is folded into Gg, so only GROUP-1 bits per group are kept.
   if ((WIDTH % GROUP) != 0 || GROUP < 2 || NG < 1 || NG > 16) begin : g_cfg_check
      $error("pipelined_block_cla: WIDTH must be a multiple of GROUP (GROUP >= 2, 1..16 groups)");
   end

   logic                           s1_ready;
   logic                           s2_ready;

   logic                           s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]               p_q, p_d;
   logic [NG-1:0][GROUP-2:0]       gl_q, gl_d;
   logic [NG-1:0]                  pg_q, pg_d;
   logic [NG-1:0]                  gg_q, gg_d;
   logic                           cin_q, cin_d;

   logic                           valid_o_q, valid_o_d;
   logic [WIDTH-1:0]               o_q, o_d;
   logic                           co_q, co_d;
`ifdef CLA_OVERFLOW_EN
   logic                           ov_q, ov_d;
`endif

   logic [WIDTH-1:0]               bb;
   logic [WIDTH-1:0]               p_new;
   logic [WIDTH-1:0]               g_new;
   logic                           cin_new;
   logic [NG-1:0][GROUP-2:0]       gl_new;
   logic [NG-1:0]                  pg_new;
   logic [NG-1:0]                  gg_new;

   logic [NG-1:0]                  cg;
   logic [NG-1:0]                  cg_in;
   logic [WIDTH-1:0]               carry_into;
   logic [WIDTH-1:0]               sum;

   assign s2_ready = !valid_o_q || bus.ready_i;
   assign s1_ready = !s1_valid_q || s2_ready;

   assign bus.ready_o = s1_ready;
   assign bus.valid_o = valid_o_q;
   assign bus.o_o     = o_q;
   assign bus.c_o     = co_q;
`ifdef CLA_OVERFLOW_EN
   assign bus.ov_o    = ov_q;
`endif

   always_comb begin : s1_prep
      logic term;
      term    = 1'b0;
      bb      = bus.sub_i ? ~bus.b_i : bus.b_i;
      cin_new = bus.sub_i ? 1'b1 : bus.c_i;
      p_new   = bus.a_i ^ bb;
      g_new   = bus.a_i & bb;
      pg_new  = '0;
      gg_new  = '0;
      gl_new  = '0;
      for (int k = 0; k < NG; k++) begin
         pg_new[k] = &p_new[k*GROUP +: GROUP];
         for (int j = 0; j < GROUP - 1; j++) begin
            gl_new[k][j] = g_new[k*GROUP + j];
         end
         // Gg = OR over j of G[j] & P[j+1..top], written as independent product terms
         for (int j = 0; j < GROUP; j++) begin
            term = g_new[k*GROUP + j];
            for (int m = j + 1; m < GROUP; m++) begin
               term = term & p_new[k*GROUP + m];
            end
            gg_new[k] = gg_new[k] | term;
         end
      end
   end

   always_comb begin : s2_carry
      logic t;
      logic acc;
      t          = 1'b0;
      acc        = 1'b0;
      cg         = '0;
      cg_in      = '0;
      carry_into = '0;
      // Group carries as flat sum-of-products over cin and every lower group
      for (int k = 0; k < NG; k++) begin
         acc = cin_q;
         for (int m = 0; m <= k; m++) begin
            acc = acc & pg_q[m];
         end
         for (int j = 0; j <= k; j++) begin
            t = gg_q[j];
            for (int m = j + 1; m <= k; m++) begin
               t = t & pg_q[m];
            end
            acc = acc | t;
         end
         cg[k] = acc;
      end
      cg_in[0] = cin_q;
      for (int k = 1; k < NG; k++) begin
         cg_in[k] = cg[k-1];
      end
      // Bit carries inside each group, again flat from the group carry-in
      for (int k = 0; k < NG; k++) begin
         for (int j = 0; j < GROUP; j++) begin
            acc = cg_in[k];
            for (int m = 0; m < j; m++) begin
               acc = acc & p_q[k*GROUP + m];
            end
            for (int m = 0; m < j; m++) begin
               t = gl_q[k][m];
               for (int n = m + 1; n < j; n++) begin
                  t = t & p_q[k*GROUP + n];
               end
               acc = acc | t;
            end
            carry_into[k*GROUP + j] = acc;
         end
      end
      sum = p_q ^ carry_into;
   end

   always_comb begin : next_state
      s1_valid_d = s1_valid_q;
      p_d        = p_q;
      gl_d       = gl_q;
      pg_d       = pg_q;
      gg_d       = gg_q;
      cin_d      = cin_q;
      valid_o_d  = valid_o_q;
      o_d        = o_q;
      co_d       = co_q;
`ifdef CLA_OVERFLOW_EN
      ov_d       = ov_q;
`endif
      if (s1_ready) begin
         s1_valid_d = bus.valid_i;
         if (bus.valid_i) begin
            p_d   = p_new;
            gl_d  = gl_new;
            pg_d  = pg_new;
            gg_d  = gg_new;
            cin_d = cin_new;
         end
      end
      // Result registers only move on a real beat so a stalled output stays put
      if (s2_ready) begin
         valid_o_d = s1_valid_q;
         if (s1_valid_q) begin
            o_d  = sum;
            co_d = cg[NG-1];
`ifdef CLA_OVERFLOW_EN
            ov_d = carry_into[WIDTH-1] ^ cg[NG-1];
`endif
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         p_q        <= '0;
         gl_q       <= '0;
         pg_q       <= '0;
         gg_q       <= '0;
         cin_q      <= 1'b0;
         valid_o_q  <= 1'b0;
         o_q        <= '0;
         co_q       <= 1'b0;
`ifdef CLA_OVERFLOW_EN
         ov_q       <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         p_q        <= p_d;
         gl_q       <= gl_d;
         pg_q       <= pg_d;
         gg_q       <= gg_d;
         cin_q      <= cin_d;
         valid_o_q  <= valid_o_d;
         o_q        <= o_d;
         co_q       <= co_d;
`ifdef CLA_OVERFLOW_EN
         ov_q       <= ov_d;
`endif
      end
   end
endmodule
